// File: rtl/fmul_arb_pkg.sv
// Shared types and the round-robin pick helper for the FMUL issue arbiter.
// Widths are sized for the largest supported requester count (8).
package fmul_arb_pkg;

   localparam int unsigned FP_W     = 32;
   localparam int unsigned NREQ_MAX = 8;
   localparam int unsigned ID_MAX_W = 3;

   typedef logic [FP_W-1:0] fp32_t;

   typedef struct packed {
      logic                valid;
      logic [ID_MAX_W-1:0] id;
   } tag_t;

   typedef struct packed {
      logic                found;
      logic [ID_MAX_W-1:0] idx;
   } pick_t;

   // First set bit of req at or above ptr, wrapping modulo n.
   function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] req,
                                     input logic [ID_MAX_W-1:0] ptr,
                                     input int unsigned         n);
      pick_t               pick;
      int unsigned         j;
      logic [ID_MAX_W-1:0] k;
      pick = '0;
      for (int unsigned i = 0; i < NREQ_MAX; i++) begin
         j = (32'(ptr) + i) % n;
         k = ID_MAX_W'(j);
         if (i < n && !pick.found && req[k]) begin
            pick.found = 1'b1;
            pick.idx   = k;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/fmul_rr_arbiter_if.sv
// Request/response bundle between the VLIW issue slots and the FMUL arbiter.
interface fmul_rr_arbiter_if
   import fmul_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
);

   logic [NREQ-1:0]      req_valid;
   logic [NREQ*FP_W-1:0] req_a;
   logic [NREQ*FP_W-1:0] req_b;
   logic [NREQ-1:0]      req_ready;
   logic                 resp_valid;
   logic [IDW-1:0]       resp_id;
   fp32_t                resp_data;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, resp_valid, resp_id, resp_data
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, resp_valid, resp_id, resp_data
   );

endinterface

// File: rtl/fmul_tag_pipe.sv
// MUL_LAT-deep shift register of in-flight tags; reset or flush clears every stage.
module fmul_tag_pipe
   import fmul_arb_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flush_i,
   input  tag_t tag_i,
   output tag_t tag_o
);

   tag_t stage_q [MUL_LAT];

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         for (int i = 0; i < MUL_LAT; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= tag_i;
         for (int i = 1; i < MUL_LAT; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign tag_o = stage_q[MUL_LAT-1];

endmodule

// File: rtl/fmul_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined FMUL among NREQ issue slots.
// Optional perf counters are built when FMUL_ARB_PERF_EN is defined.
module fmul_rr_arbiter
   import fmul_arb_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IDW     = 2,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   fmul_rr_arbiter_if.slave bus,
   output fp32_t            mul_a,
   output fp32_t            mul_b,
`ifdef FMUL_ARB_PERF_EN
   output logic [31:0]      perf_issue,
   output logic [31:0]      perf_conflict,
`endif
   input  fp32_t            mul_out
);

   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   fp32_t          mul_a_q, mul_a_d;
   fp32_t          mul_b_q, mul_b_d;
   tag_t           issue_q, issue_d;
   tag_t           tag_out;
   pick_t          pick;
   logic [IDW-1:0] winner;
   logic           hs;

   always_comb begin
      pick          = rr_pick(NREQ_MAX'(bus.req_valid), ID_MAX_W'(rr_ptr_q), NREQ);
      winner        = IDW'(pick.idx);
      bus.req_ready = '0;
      if (rst_n && !flush && pick.found) bus.req_ready[winner] = 1'b1;
      hs            = |(bus.req_valid & bus.req_ready);

      issue_d       = '0;
      issue_d.valid = hs;
      issue_d.id    = pick.idx;
      rr_ptr_d      = rr_ptr_q;
      mul_a_d       = mul_a_q;
      mul_b_d       = mul_b_q;
      if (hs) begin
         rr_ptr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
         mul_a_d  = bus.req_a[FP_W*winner +: FP_W];
         mul_b_d  = bus.req_b[FP_W*winner +: FP_W];
      end
   end

   // The issue tag sits beside the operand register; the pipe then tracks the
   // multiplier's MUL_LAT stages so the tag lines up with mul_out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         issue_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         issue_q  <= flush ? '0 : issue_d;
      end
   end

   fmul_tag_pipe #(
      .MUL_LAT (MUL_LAT)
   ) u_tag_pipe (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (flush),
      .tag_i   (issue_q),
      .tag_o   (tag_out)
   );

   assign mul_a          = mul_a_q;
   assign mul_b          = mul_b_q;
   assign bus.resp_valid = tag_out.valid;
   assign bus.resp_id    = IDW'(tag_out.id);
   assign bus.resp_data  = mul_out;

`ifdef FMUL_ARB_PERF_EN
   logic [31:0] perf_issue_q, perf_conflict_q;
   logic        multi_req;

   assign multi_req = $countones(bus.req_valid) > 1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_issue_q    <= '0;
         perf_conflict_q <= '0;
      end else if (!flush) begin
         if (hs)        perf_issue_q    <= perf_issue_q + 32'd1;
         if (multi_req) perf_conflict_q <= perf_conflict_q + 32'd1;
      end
   end

   assign perf_issue    = perf_issue_q;
   assign perf_conflict = perf_conflict_q;
`endif

endmodule
